// File: rtl/fti16_pkg.sv
// Shared types for the float-to-int16 arbiter: operand/result typedefs, the
// stage-entry records carried by the two pipeline registers, and occupancy decoding.
package fti16_pkg;

    localparam int NUM_REQ_DEFAULT = 4;
    // Wide enough for the largest supported lane count (16).
    localparam int ID_W_MAX = 4;

    typedef logic [31:0] float32_t;
    typedef logic [15:0] int16_t;

    typedef struct packed {
        logic                valid;
        logic [ID_W_MAX-1:0] id;
        float32_t            data;
    } s1_entry_t;

    typedef struct packed {
        logic                valid;
        logic [ID_W_MAX-1:0] id;
        int16_t              data;
    } s2_entry_t;

    typedef enum logic [1:0] {
        OCC_EMPTY,
        OCC_HALF,
        OCC_FULL
    } occ_e;

    function automatic occ_e occupancy(input logic s1_valid, input logic s2_valid);
        case ({s1_valid, s2_valid})
            2'b00:   return OCC_EMPTY;
            2'b11:   return OCC_FULL;
            default: return OCC_HALF;
        endcase
    endfunction

endpackage

// File: rtl/float_to_int16.sv
// Combinational IEEE-754 single to int16 conversion: truncates toward zero,
// saturates out-of-range values and infinities, and maps NaN to zero.
module float_to_int16
    import fti16_pkg::*;
(
    input  float32_t float_in,
    output int16_t   int_out
);

    logic       sign;
    logic [7:0] exp_b;
    logic [22:0] frac;
    logic [4:0] shift;
    int16_t     mag;
    int16_t     sat;

    assign sign  = float_in[31];
    assign exp_b = float_in[30:23];
    assign frac  = float_in[22:0];
    assign sat   = sign ? 16'h8000 : 16'h7FFF;

    always_comb begin
        // NOTE: every signal written here gets a default first, so no latch is inferred.
        int_out = '0;
        shift   = '0;
        mag     = '0;
        if (exp_b == 8'hFF) begin
            int_out = (frac != '0) ? 16'h0000 : sat;
        end else if (exp_b >= 8'd142) begin
            int_out = sat;
        end else if (exp_b >= 8'd127) begin
            // Unbiased exponent 0..14: the integer part is the mantissa shifted right by 23-e.
            shift   = 5'(8'd150 - exp_b);
            mag     = 16'({1'b1, frac} >> shift);
            int_out = sign ? -mag : mag;
        end
    end

endmodule

// File: rtl/float_to_int16_arbiter.sv
// Round-robin arbiter feeding one shared float_to_int16 converter through a
// two-stage (S1 operand, S2 result) elastic pipeline with a valid/ready response port.
module float_to_int16_arbiter
    import fti16_pkg::*;
#(
    parameter  int NUM_REQ = NUM_REQ_DEFAULT,
    localparam int IDW     = $clog2(NUM_REQ)
)(
    input  logic                  clk,
    input  logic                  rst,
    input  logic [NUM_REQ-1:0]    req_valid,
    input  logic [32*NUM_REQ-1:0] req_data,
    output logic [NUM_REQ-1:0]    req_ready,
    output logic                  rsp_valid,
    input  logic                  rsp_ready,
    output logic [IDW-1:0]        rsp_id,
    output logic [15:0]           rsp_data,
    output logic                  busy
);

    logic [IDW-1:0] ptr_q, ptr_d;
    logic [IDW-1:0] grant;
    logic           any_req;
    logic           s2_free;
    logic           s1_adv;
    logic           s1_can_load;
    logic           accept;
    s1_entry_t      s1_q, s1_d;
    s2_entry_t      s2_q, s2_d;
    int16_t         conv;
    occ_e           occ;

    // First valid lane at or after the pointer, wrapping past the last lane.
    always_comb begin
        int             idx;
        logic [IDW-1:0] lane;
        grant   = '0;
        any_req = 1'b0;
        idx     = 0;
        lane    = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            idx = int'(ptr_q) + k;
            if (idx >= NUM_REQ) idx = idx - NUM_REQ;
            lane = IDW'(idx);
            if (!any_req && req_valid[lane]) begin
                any_req = 1'b1;
                grant   = lane;
            end
        end
    end

    float_to_int16 u_conv (
        .float_in (s1_q.data),
        .int_out  (conv)
    );

    always_comb begin
        s2_free     = !s2_q.valid || rsp_ready;
        s1_adv      = s1_q.valid && s2_free;
        s1_can_load = !s1_q.valid || s1_adv;
        // Flops are already cleared under rst, so gate here to keep every ready low.
        accept      = any_req && s1_can_load && !rst;

        req_ready = '0;
        if (accept) req_ready[grant] = 1'b1;

        ptr_d = ptr_q;
        if (accept) ptr_d = (grant == IDW'(NUM_REQ - 1)) ? '0 : grant + 1'b1;

        s1_d = s1_q;
        if (s1_adv) s1_d.valid = 1'b0;
        if (accept) begin
            s1_d.valid = 1'b1;
            s1_d.id    = ID_W_MAX'(grant);
            s1_d.data  = req_data[32*grant +: 32];
        end

        s2_d = s2_q;
        if (s2_q.valid && rsp_ready) s2_d.valid = 1'b0;
        if (s1_adv) begin
            s2_d.valid = 1'b1;
            s2_d.id    = s1_q.id;
            s2_d.data  = conv;
        end

        occ = occupancy(s1_q.valid, s2_q.valid);
    end

    // NOTE: sequential state uses non-blocking assignments so all flops update together.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ptr_q <= '0;
            // NOTE: payload fields are reset too, because rsp_id/rsp_data must read zero in reset.
            s1_q  <= '0;
            s2_q  <= '0;
        end else begin
            ptr_q <= ptr_d;
            s1_q  <= s1_d;
            s2_q  <= s2_d;
        end
    end

    assign rsp_valid = s2_q.valid;
    assign rsp_id    = IDW'(s2_q.id);
    assign rsp_data  = s2_q.data;
    assign busy      = (occ != OCC_EMPTY);

endmodule

// File: doc/float_to_int16_arbiter.md
FLOAT_TO_INT16_ARBITER -- requirements
Module: float_to_int16_arbiter

Interface
REQ-001 SHALL have parameter NUM_REQ, default 4: the number of requester lanes sharing one converter (legal range 2..16).
REQ-002 SHALL have localparam IDW = $clog2(NUM_REQ): the width of the requester ID.
REQ-003 SHALL have port clk  input  1  the single clock; all state is updated on its rising edge.
REQ-004 SHALL have port rst  input  1  asynchronous, active-high reset.
REQ-005 SHALL have port req_valid  input  NUM_REQ  per-lane request valid.
REQ-006 SHALL have port req_data  input  32*NUM_REQ  per-lane IEEE-754 single-precision operand, with lane i at bits [32i+31:32i].
REQ-007 SHALL have port req_ready  output  NUM_REQ  per-lane accept; at most one bit is high in any cycle.
REQ-008 SHALL have port rsp_valid  output  1  result valid.
REQ-009 SHALL have port rsp_ready  input  1  downstream accept.
REQ-010 SHALL have port rsp_id  output  IDW  the index of the lane that issued the result.
REQ-011 SHALL have port rsp_data  output  16  the int16 result.
REQ-012 SHALL have port busy  output  1  high while any pipeline stage holds a valid entry.

Function
REQ-013 Transfers: a lane transfer occurs when req_valid[i] and req_ready[i] are both high on a clock edge; a response transfer occurs when rsp_valid and rsp_ready are both high on a clock edge.
REQ-014 Arbitration SHALL be round-robin: the grant goes to the lowest-index valid lane at or after pointer ptr, wrapping from NUM_REQ-1 to 0.
REQ-015 Pointer update: on a lane transfer, ptr SHALL become (grant+1) mod NUM_REQ; otherwise ptr SHALL hold, including when no lane is requesting.
REQ-016 req_ready[grant] SHALL be high only when stage S1 can load (S1 empty, or S1 advancing this cycle); all other req_ready bits SHALL be low.
REQ-017 Pipeline, stage S1: S1 SHALL register the accepted operand together with its ID and a valid bit.
REQ-018 Pipeline, stage S2: S2 SHALL register the converted result together with its ID; S2 drives rsp_valid, rsp_id and rsp_data.
REQ-019 S2 SHALL load when S1 is valid and S2 is either empty or completing a response transfer; S1 advances under the same condition.
REQ-020 The conversion SHALL be exactly the output of the existing combinational float_to_int16 applied to the S1 operand; the arbiter SHALL NOT modify that value.
REQ-021 Latency SHALL be 2 cycles from lane transfer to rsp_valid when the pipeline is unstalled.
REQ-022 Throughput SHALL be 1 transfer per cycle when a lane transfer and a response transfer occur in the same cycle.
REQ-023 Occupancy states: EMPTY (no stage valid), HALF (exactly one stage valid) and FULL (both stages valid), derived from the two stage valid bits.
REQ-024 In FULL with rsp_ready low, all req_ready bits SHALL be low and S1/S2 contents SHALL hold.
REQ-025 While rsp_valid is high and rsp_ready is low, rsp_id and rsp_data SHALL remain stable until the response transfer.
REQ-026 Results SHALL leave the block in acceptance order; none is dropped or duplicated.
REQ-027 busy SHALL equal (S1 valid OR S2 valid).

Reset
REQ-028 On rst high, asynchronously: ptr=0, S1 and S2 valid bits=0, rsp_valid=0, busy=0, and rsp_id and rsp_data=0.
REQ-029 Entries in flight when reset asserts SHALL be discarded; req_ready SHALL be all-zero while rst is high.
REQ-030 After rst deasserts, the first grant SHALL go to the lowest-index valid lane starting from lane 0.

Structure
REQ-031 Package fti16_pkg SHALL hold the NUM_REQ default, the float32_t (32-bit) and int16_t (16-bit) typedefs, and the stage-entry struct {valid, id, data}.
REQ-032 The existing float_to_int16 SHALL be the single instantiated sub-module, placed between S1 and S2; no other sub-modules SHALL be used.

Verification
REQ-033 Single lane: lane 2 sends 0x3F800000 with rsp_ready=1 -> rsp_valid 2 cycles later, rsp_id=2, rsp_data=0x0001.
REQ-034 Round-robin: all 4 lanes valid continuously (lanes 0..3 = 0xC4800000, 0x44800000, 0xC2C80000, 0x00000000), rsp_ready=1 -> grant order 0,1,2,3,0,... and results 0xFC00, 0x0400, 0xFF9C, 0x0000 at 1 per cycle.
REQ-035 Backpressure: hold rsp_ready=0 for 5 cycles while lane 1 is valid -> exactly 2 lane transfers then req_ready=0; rsp_data holds 0x0400; after release, results drain in order with no loss.
REQ-036 Wrap and skip: ptr=3 with only lanes 1 and 3 valid -> grant 3, then 1, then 3.
REQ-037 Reset mid-operation: assert rst while FULL -> rsp_valid and busy fall immediately without waiting for a clock edge; after release no stale result appears and the first grant goes to lane 0.
